// File: rtl/uart_paddle_cmd.sv
// uart_paddle_cmd: turns received UART bytes into player-1 paddle move strobes.
// A direction byte starts a hold window; while it is open the move strobe
// auto-repeats every REPEAT_CYCLES. START bytes raise a start request and
// unrecognised bytes are counted (saturating) for debug.
//
// Input handshake: data_valid is a one-cycle strobe with no ready/back-pressure.
// rx_byte is decoded in every cycle where data_valid=1. A strobe held high for
// several cycles counts as one byte per cycle.
module uart_paddle_cmd #(
  parameter int          HOLD_CYCLES   = 2500000,
  parameter int          REPEAT_CYCLES = 1250000,
  parameter logic [7:0]  UP_CHAR       = 8'h77,
  parameter logic [7:0]  DOWN_CHAR     = 8'h73,
  parameter logic [7:0]  STOP_CHAR     = 8'h20,
  parameter logic [7:0]  START_CHAR    = 8'h67
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [7:0] rx_byte,
  output logic       move_up,
  output logic       move_down,
  output logic       start_req,
  output logic [1:0] dir_state,
  output logic [7:0] bad_cmd_cnt
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LOAD  = CW'(REPEAT_CYCLES - 1);

  // The encoding doubles as the dir_state debug view of the FSM.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } state_t;

  // Fold ASCII upper case onto lower case so 'W' and 'w' decode alike.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) begin
      return c | 8'h20;
    end
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] rep_q, rep_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic          start_q, start_d;
  logic [7:0]    bad_q, bad_d;

  logic [7:0] rx_fold;
  logic       is_up, is_down, is_stop, is_start, is_bad;

  // Byte classification, only meaningful while data_valid is high.
  always_comb begin
    rx_fold  = fold_case(rx_byte);
    is_up    = data_valid && (rx_fold == fold_case(UP_CHAR));
    is_down  = data_valid && (rx_fold == fold_case(DOWN_CHAR));
    is_stop  = data_valid && (rx_fold == fold_case(STOP_CHAR));
    is_start = data_valid && (rx_fold == fold_case(START_CHAR));
    is_bad   = data_valid && !(is_up || is_down || is_stop || is_start);
  end

  // Registered state, counters and strobes; reset clears everything at once.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      rep_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      start_q <= 1'b0;
      bad_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      up_q    <= up_d;
      down_q  <= down_d;
      start_q <= start_d;
      bad_q   <= bad_d;
    end
  end

  // Next state: a move/stop byte overrides the timers; otherwise the hold
  // window counts down and the repeat timer produces periodic strobes.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    start_d = is_start;
    bad_d   = bad_q;

    if (is_bad && (bad_q != 8'hFF)) begin
      bad_d = bad_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (is_up) begin
          state_d = S_UP;
          up_d    = 1'b1;
          hold_d  = HOLD_LOAD;
          rep_d   = REP_LOAD;
        end else if (is_down) begin
          state_d = S_DOWN;
          down_d  = 1'b1;
          hold_d  = HOLD_LOAD;
          rep_d   = REP_LOAD;
        end
      end
      S_UP, S_DOWN: begin
        if (is_up) begin
          state_d = S_UP;
          up_d    = 1'b1;
          hold_d  = HOLD_LOAD;
          rep_d   = REP_LOAD;
        end else if (is_down) begin
          state_d = S_DOWN;
          down_d  = 1'b1;
          hold_d  = HOLD_LOAD;
          rep_d   = REP_LOAD;
        end else if (is_stop) begin
          state_d = S_IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end else if (hold_q == '0) begin
          // Expiry wins over a coincident repeat tick: leave silently.
          state_d = S_IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end else begin
          hold_d = hold_q - CW'(1);
          if (rep_q == '0) begin
            rep_d = REP_LOAD;
            // A start strobe this cycle takes the single strobe slot.
            if (!is_start) begin
              up_d   = (state_q == S_UP);
              down_d = (state_q == S_DOWN);
            end
          end else begin
            rep_d = rep_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end

  assign move_up     = up_q;
  assign move_down   = down_q;
  assign start_req   = start_q;
  assign dir_state   = state_q;
  assign bad_cmd_cnt = bad_q;

endmodule

// File: tb/tb_uart_paddle_cmd.sv
// Directed bench for uart_paddle_cmd with HOLD_CYCLES=20, REPEAT_CYCLES=5.
// Cycle n is the interval after the n-th rising edge; a byte driven in cycle t
// produces its strobe in cycle t+1. Outputs are logged on the falling edge.
module tb_uart_paddle_cmd;

  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int LOGN = 4096;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic       data_valid;
  logic [7:0] rx_byte;
  logic       move_up, move_down, start_req;
  logic [1:0] dir_state;
  logic [7:0] bad_cmd_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_paddle_cmd #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_in     (clk),
    .reset      (reset),
    .data_valid (data_valid),
    .rx_byte    (rx_byte),
    .move_up    (move_up),
    .move_down  (move_down),
    .start_req  (start_req),
    .dir_state  (dir_state),
    .bad_cmd_cnt(bad_cmd_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       up_log  [LOGN];
  logic       dn_log  [LOGN];
  logic       st_log  [LOGN];
  logic [1:0] dir_log [LOGN];

  always @(negedge clk) begin
    up_log[cyc % LOGN]  = move_up;
    dn_log[cyc % LOGN]  = move_down;
    st_log[cyc % LOGN]  = start_req;
    dir_log[cyc % LOGN] = dir_state;
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // kind: 0 = any strobe, 1 = move_up, 2 = move_down, 3 = start_req
  function automatic int count_log(input int kind, input int a, input int b);
    int n;
    n = 0;
    for (int i = a; i <= b; i++) begin
      case (kind)
        1:       n += int'(up_log[i % LOGN]);
        2:       n += int'(dn_log[i % LOGN]);
        3:       n += int'(st_log[i % LOGN]);
        default: n += int'(up_log[i % LOGN]) + int'(dn_log[i % LOGN]) + int'(st_log[i % LOGN]);
      endcase
    end
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_valid = 1'b1;
    rx_byte    = b;
    tick(1);
    data_valid = 1'b0;
    rx_byte    = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       exp_up;
    logic       exp_dn;
    logic       exp_st;
    logic [1:0] exp_dir;
    logic [7:0] exp_bad;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int t;
    int nz;

    vecs[0]  = '{8'h77, 1'b1, 1'b0, 1'b0, 2'b01, 8'd0};
    vecs[1]  = '{8'h57, 1'b1, 1'b0, 1'b0, 2'b01, 8'd0};
    vecs[2]  = '{8'h73, 1'b0, 1'b1, 1'b0, 2'b10, 8'd0};
    vecs[3]  = '{8'h53, 1'b0, 1'b1, 1'b0, 2'b10, 8'd0};
    vecs[4]  = '{8'h67, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[5]  = '{8'h47, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0};
    vecs[6]  = '{8'h20, 1'b0, 1'b0, 1'b0, 2'b00, 8'd0};
    vecs[7]  = '{8'h41, 1'b0, 1'b0, 1'b0, 2'b00, 8'd1};
    vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 8'd2};
    vecs[9]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 2'b00, 8'd3};
    vecs[10] = '{8'h78, 1'b0, 1'b0, 1'b0, 2'b00, 8'd4};
    vecs[11] = '{8'h21, 1'b0, 1'b0, 1'b0, 2'b00, 8'd5};

    reset      = 1'b1;
    data_valid = 1'b0;
    rx_byte    = 8'h00;
    #1;
    chk("reset_move_up",   {31'd0, move_up},   32'd0);
    chk("reset_move_down", {31'd0, move_down}, 32'd0);
    chk("reset_start_req", {31'd0, start_req}, 32'd0);
    chk("reset_dir",       {30'd0, dir_state}, 32'd0);
    chk("reset_bad_cnt",   {24'd0, bad_cmd_cnt}, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(1);

    // Test 1: idle for 50 cycles.
    t = cyc;
    tick(51);
    chk("idle_no_pulses", count_log(0, t, t + 50), 32'd0);
    nz = 0;
    for (int i = t; i <= t + 50; i++) nz += (dir_log[i % LOGN] != 2'b00) ? 1 : 0;
    chk("idle_dir", nz, 32'd0);
    chk("idle_bad_cnt", {24'd0, bad_cmd_cnt}, 32'd0);

    // Table: single bytes decoded from IDLE, then a STOP returns to IDLE.
    for (int k = 0; k < 12; k++) begin
      send_byte(vecs[k].b);
      chk($sformatf("vec%0d_up", k),  {31'd0, move_up},     {31'd0, vecs[k].exp_up});
      chk($sformatf("vec%0d_dn", k),  {31'd0, move_down},   {31'd0, vecs[k].exp_dn});
      chk($sformatf("vec%0d_st", k),  {31'd0, start_req},   {31'd0, vecs[k].exp_st});
      chk($sformatf("vec%0d_dir", k), {30'd0, dir_state},   {30'd0, vecs[k].exp_dir});
      chk($sformatf("vec%0d_bad", k), {24'd0, bad_cmd_cnt}, {24'd0, vecs[k].exp_bad});
      send_byte(8'h20);
      chk($sformatf("vec%0d_pulse_end", k), {29'd0, move_up, move_down, start_req}, 32'd0);
      chk($sformatf("vec%0d_stop_idle", k), {30'd0, dir_state}, 32'd0);
      tick(1);
    end

    // Test 2: single 'w', auto-repeat then expiry.
    tick(2);
    t = cyc;
    send_byte(8'h77);
    tick(30);
    chk("t2_up_t1",  {31'd0, up_log[(t + 1) % LOGN]},  32'd1);
    chk("t2_up_t6",  {31'd0, up_log[(t + 6) % LOGN]},  32'd1);
    chk("t2_up_t11", {31'd0, up_log[(t + 11) % LOGN]}, 32'd1);
    chk("t2_up_t16", {31'd0, up_log[(t + 16) % LOGN]}, 32'd1);
    chk("t2_up_total", count_log(1, t, t + 30), 32'd4);
    chk("t2_other_pulses", count_log(2, t, t + 30) + count_log(3, t, t + 30), 32'd0);
    chk("t2_dir_t1",  {30'd0, dir_log[(t + 1) % LOGN]},  32'd1);
    chk("t2_dir_t19", {30'd0, dir_log[(t + 19) % LOGN]}, 32'd1);
    chk("t2_dir_t22", {30'd0, dir_log[(t + 22) % LOGN]}, 32'd0);
    chk("t2_no_pulse_expiry", count_log(0, t + 17, t + 30), 32'd0);

    // Test 3: 'w' then 'S' three cycles later.
    t = cyc;
    send_byte(8'h77);
    tick(2);
    send_byte(8'h53);
    tick(10);
    chk("t3_up_t1",   {31'd0, up_log[(t + 1) % LOGN]},  32'd1);
    chk("t3_dn_t4",   {31'd0, dn_log[(t + 4) % LOGN]},  32'd1);
    chk("t3_dn_t9",   {31'd0, dn_log[(t + 9) % LOGN]},  32'd1);
    chk("t3_dn_gap",  count_log(2, t + 5, t + 8), 32'd0);
    chk("t3_dir_t3",  {30'd0, dir_log[(t + 3) % LOGN]}, 32'd1);
    chk("t3_dir_t4",  {30'd0, dir_log[(t + 4) % LOGN]}, 32'd2);
    chk("t3_no_up",   count_log(1, t + 2, t + 13), 32'd0);
    send_byte(8'h20);
    tick(2);

    // Test 4: second 'w' coincides with the repeat tick.
    t = cyc;
    send_byte(8'h77);
    tick(4);
    send_byte(8'h77);
    tick(30);
    chk("t4_single_up", count_log(1, t + 5, t + 8), 32'd1);
    chk("t4_up_t6",  {31'd0, up_log[(t + 6) % LOGN]},  32'd1);
    chk("t4_up_t11", {31'd0, up_log[(t + 11) % LOGN]}, 32'd1);
    chk("t4_up_t16", {31'd0, up_log[(t + 16) % LOGN]}, 32'd1);
    chk("t4_up_t21", {31'd0, up_log[(t + 21) % LOGN]}, 32'd1);
    chk("t4_up_total", count_log(1, t, t + 34), 32'd5);
    chk("t4_no_pulse_expiry", count_log(0, t + 22, t + 34), 32'd0);
    chk("t4_dir_t24", {30'd0, dir_log[(t + 24) % LOGN]}, 32'd1);
    chk("t4_dir_t27", {30'd0, dir_log[(t + 27) % LOGN]}, 32'd0);

    // Test 5: start request and bad-byte counter saturation.
    do_reset();
    t = cyc;
    send_byte(8'h77);
    send_byte(8'h67);
    send_byte(8'h41);
    tick(3);
    chk("t5_st_t1",  {31'd0, st_log[(t + 1) % LOGN]}, 32'd0);
    chk("t5_st_t2",  {31'd0, st_log[(t + 2) % LOGN]}, 32'd1);
    chk("t5_st_t3",  {31'd0, st_log[(t + 3) % LOGN]}, 32'd0);
    chk("t5_dir_t2", {30'd0, dir_log[(t + 2) % LOGN]}, 32'd1);
    chk("t5_dir_t3", {30'd0, dir_log[(t + 3) % LOGN]}, 32'd1);
    chk("t5_bad_one", {24'd0, bad_cmd_cnt}, 32'd1);
    for (int i = 0; i < 253; i++) send_byte(8'h41);
    chk("t5_bad_fe", {24'd0, bad_cmd_cnt}, 32'hFE);
    send_byte(8'h41);
    chk("t5_bad_ff", {24'd0, bad_cmd_cnt}, 32'hFF);
    for (int i = 0; i < 46; i++) send_byte(8'h41);
    chk("t5_bad_sat", {24'd0, bad_cmd_cnt}, 32'hFF);
    tick(25);

    // Test 6: STOP cancels UP, then reset mid-UP.
    t = cyc;
    send_byte(8'h77);
    tick(1);
    send_byte(8'h20);
    tick(12);
    chk("t6_dir_t2",   {30'd0, dir_log[(t + 2) % LOGN]}, 32'd1);
    chk("t6_dir_t3",   {30'd0, dir_log[(t + 3) % LOGN]}, 32'd0);
    chk("t6_no_pulse", count_log(0, t + 2, t + 14), 32'd0);

    send_byte(8'h77);
    chk("t6_up_before_rst", {31'd0, move_up}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_up",  {31'd0, move_up},   32'd0);
    chk("t6_rst_dir", {30'd0, dir_state}, 32'd0);
    chk("t6_rst_bad", {24'd0, bad_cmd_cnt}, 32'd0);
    tick(2);
    reset = 1'b0;
    t = cyc;
    tick(30);
    chk("t6_post_rst_pulses", count_log(0, t, t + 29), 32'd0);
    nz = 0;
    for (int i = t; i <= t + 29; i++) nz += (dir_log[i % LOGN] != 2'b00) ? 1 : 0;
    chk("t6_post_rst_dir", nz, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_paddle_cmd.md
Name: uart_paddle_cmd

Overview:
Command decoder between uart_receiver and paddle1_ctrl. It takes the received byte and its one-cycle valid strobe and produces registered single-cycle paddle move strobes for player 1. While a direction command remains active it auto-repeats those strobes, and it emits a start request. It also counts unrecognised bytes for debug.

Parameters:
HOLD_CYCLES, 2500000, cycles a direction stays active after its last matching byte (100 ms at 25 MHz)
REPEAT_CYCLES, 1250000, period between auto-repeat move strobes while a direction is active
UP_CHAR, 8'h77, ASCII 'w'; 8'h57 ('W') is also accepted
DOWN_CHAR, 8'h73, ASCII 's'; 8'h53 ('S') is also accepted
STOP_CHAR, 8'h20, ASCII space; cancels any active direction
START_CHAR, 8'h67, ASCII 'g'; 8'h47 ('G') is also accepted

Ports:
clk_in  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-high reset
data_valid  input  1  one-cycle strobe from uart_receiver; rx_byte is valid in that cycle
rx_byte  input  8  received byte
move_up  output  1  one-cycle pulse: move paddle up one step
move_down  output  1  one-cycle pulse: move paddle down one step
start_req  output  1  one-cycle pulse: start game request, ORed with the debounced button upstream of gameCtrl_FSM
dir_state  output  2  00 IDLE, 01 UP, 10 DOWN; 11 is never driven
bad_cmd_cnt  output  8  saturating count of unrecognised bytes

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - All pulses drop to 0. dir_state=00, bad_cmd_cnt=0.
  - hold_cnt and rep_cnt clear.
- All outputs are registered. A strobe appears exactly 1 cycle after the data_valid cycle that causes it.
- Byte decode happens only when data_valid=1. Upper and lower case letters are treated the same.
- FSM states: IDLE, UP, DOWN.
- IDLE:
  - UP byte → move_up pulse, go to UP, hold_cnt=HOLD_CYCLES-1, rep_cnt=REPEAT_CYCLES-1.
  - DOWN byte → same, mirrored, into DOWN.
  - STOP byte → no effect.
- UP (DOWN is symmetric):
  - Each cycle without a command, hold_cnt and rep_cnt decrement.
  - When rep_cnt is 0 → move_up pulse and reload rep_cnt.
  - When hold_cnt is 0 → go to IDLE with no pulse that cycle. Expiry takes priority over a repeat pulse.
  - Same-direction byte → immediate move_up pulse, reload both counters (models keyboard auto-repeat).
  - Opposite-direction byte → immediate move_down pulse, switch to DOWN, reload both counters.
  - STOP byte → go to IDLE, no pulse.
- Command vs timer priority: a byte arriving in the same cycle as hold expiry or a repeat tick wins. Only its own effect occurs: no double pulse, and no expiry to IDLE when the byte is UP or DOWN.
- START byte:
  - Produces a start_req pulse in any state.
  - Does not change the FSM state or the counters. Counters keep decrementing in that cycle.
- Any other byte increments bad_cmd_cnt, saturating at 8'hFF. The FSM and counters are unaffected and keep decrementing.
- Pulse rules:
  - move_up and move_down are never high in the same cycle.
  - At most one strobe per cycle across move_up, move_down and start_req.
- data_valid held high for several cycles is treated as one byte per cycle. The upstream guarantees a single-cycle strobe, so no edge detection is needed.
- Counter width is $clog2 of the larger of HOLD_CYCLES and REPEAT_CYCLES. Both parameters must be ≥2. The counters never wrap: they are reloaded or stopped before underflow.
- dir_state reflects the registered FSM state in the same cycle that the triggering strobe is asserted.
- Reset asserted mid-operation: outputs clear immediately (asynchronous). After reset release, no pulse occurs until a new valid byte arrives.

Test Plan:
(Directed runs use HOLD_CYCLES=20, REPEAT_CYCLES=5.)
1. Reset, then idle for 50 cycles → all outputs 0, dir_state=00.
2. Single 'w' at cycle t:
   - move_up high at t+1, t+6, t+11, t+16.
   - dir_state=01 from t+1.
   - Return to IDLE at t+20, with no pulse at t+20 or t+21.
3. 'w' at t, then 'S' at t+3:
   - move_up at t+1, move_down at t+4.
   - Next move_down at t+9. dir_state=10 from t+4.
   - No move_up after t+1.
4. 'w' at t, then 'w' at t+5 (coincides with the repeat tick):
   - Exactly one move_up at t+6.
   - Next pulse at t+11. IDLE at t+25.
5. 'w', then 'g', then 0x41:
   - start_req is a one-cycle pulse; dir_state stays 01.
   - bad_cmd_cnt=1.
   - A further 300 bad bytes leave bad_cmd_cnt=8'hFF.
6. 'w', then space after 2 cycles:
   - dir_state=00, no further pulses.
   - Reset asserted mid-UP → outputs 0 immediately, no pulses after release.
